hazard_scoreboard_unit: RTL and testbench

//  Hazard unit for the 5-stage RV32 pipeline (F,D,E,M,W); replaces the combinational hazard unit.

---
 rtl/hazard_scoreboard_unit.sv | 192 +++++++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_unit
// Purpose  : Hazard control for a 5-stage RV32 pipeline (F,D,E,M,W).
//            - per-register pending-write scoreboard for multicycle ops
//            - I/D-cache miss freeze FSM
//            - two-source operand forwarding (M beats W)
//            - saturating stall / miss performance counters
// Ports    : CPU_CLK, CPU_RST             clock, synchronous active-high reset
//            ICacheMiss, DCacheMiss       level miss indications
//            BranchE, JalrE, JalD         control-flow redirects
//            Rs1D/Rs2D/Rs1E/Rs2E          source indices in D / E
//            RdE/RdM/RdW                  destination indices in E / M / W
//            RegReadD/RegReadE            [1]=rs1 used, [0]=rs2 used
//            RegWriteM/RegWriteW          stage writes Rd
//            MemToRegE, LongOpE           load / multicycle op in E
//            LongDoneW, LongRdW           multicycle writeback
//            StallF..W, FlushF..W         stage hold / bubble controls
//            Forward1E, Forward2E         00 regfile, 10 from M, 01 from W
//            StallCnt, MissCnt            saturating perf counters
// Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard_unit #(
  parameter int REG_AW   = 5,
  parameter int MAX_LONG = 4,
  parameter int CNT_W    = 32
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST,
  input  logic              ICacheMiss,
  input  logic              DCacheMiss,
  input  logic              BranchE,
  input  logic              JalrE,
  input  logic              JalD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [1:0]        RegReadD,
  input  logic [1:0]        RegReadE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemToRegE,
  input  logic              LongOpE,
  input  logic              LongDoneW,
  input  logic [REG_AW-1:0] LongRdW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushF,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        Forward1E,
  output logic [1:0]        Forward2E,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  MissCnt
);

  localparam int c_NREG  = 1 << REG_AW;
  localparam int c_OUT_W = $clog2(MAX_LONG + 1);
  localparam logic [c_OUT_W-1:0] c_MAX_OUT = c_OUT_W'(MAX_LONG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DMISS = 2'd1,
    S_IMISS = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [c_NREG-1:0]  pending_q, pending_d;
  logic [c_OUT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0]   stall_cnt_q, miss_cnt_q;

  logic w_freeze, w_struct, w_redir_e, w_raw1, w_raw2;
  logic w_fwd1_m, w_fwd1_w, w_fwd2_m, w_fwd2_w;
  logic w_issue, w_done, w_miss_evt;

  // Freeze covers the entry cycle (miss already high) and every cycle the FSM
  // is not idle, including the exit cycle where both misses have dropped.
  assign w_freeze  = (state_q != S_IDLE) | ICacheMiss | DCacheMiss;
  // Structural: no free slot, or the op would overwrite a still-pending Rd (WAW).
  assign w_struct  = LongOpE & ((outst_q == c_MAX_OUT) | pending_q[RdE]);
  assign w_redir_e = BranchE | JalrE;
  // Load-use and multicycle-use: producer still in E or result still pending.
  assign w_raw1 = RegReadD[1] & (Rs1D != '0) &
                  (pending_q[Rs1D] | ((MemToRegE | LongOpE) & (RdE == Rs1D)));
  assign w_raw2 = RegReadD[0] & (Rs2D != '0) &
                  (pending_q[Rs2D] | ((MemToRegE | LongOpE) & (RdE == Rs2D)));

  always_comb begin
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0; StallW = 1'b0;
    FlushF = 1'b0; FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0; FlushW = 1'b0;
    if (CPU_RST) begin
      FlushF = 1'b1; FlushD = 1'b1; FlushE = 1'b1; FlushM = 1'b1; FlushW = 1'b1;
    end else if (w_freeze) begin
      // Redirects in E are held in place and take effect after the freeze.
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
      FlushW = 1'b1;
    end else if (w_struct) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1;
      FlushM = 1'b1;
    end else if (w_redir_e) begin
      FlushD = 1'b1; FlushE = 1'b1;
    end else if (JalD) begin
      FlushD = 1'b1;
    end else if (w_raw1 | w_raw2) begin
      StallF = 1'b1; StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign w_fwd1_m = RegReadE[1] & RegWriteM & (RdM != '0) & (RdM == Rs1E);
  assign w_fwd1_w = RegReadE[1] & RegWriteW & (RdW != '0) & (RdW == Rs1E);
  assign w_fwd2_m = RegReadE[0] & RegWriteM & (RdM != '0) & (RdM == Rs2E);
  assign w_fwd2_w = RegReadE[0] & RegWriteW & (RdW != '0) & (RdW == Rs2E);

  assign Forward1E = CPU_RST  ? 2'b00 :
                     w_fwd1_m ? 2'b10 :
                     w_fwd1_w ? 2'b01 : 2'b00;
  assign Forward2E = CPU_RST  ? 2'b00 :
                     w_fwd2_m ? 2'b10 :
                     w_fwd2_w ? 2'b01 : 2'b00;

  // A long op only enters the scoreboard when it actually leaves E this cycle.
  assign w_issue = LongOpE & (RdE != '0) & ~StallE & ~FlushE;
  // A completion with nothing outstanding is stale and ignored.
  assign w_done  = LongDoneW & (outst_q != '0);

  always_comb begin
    pending_d = pending_q;
    if (w_done) pending_d[LongRdW] = 1'b0;
    // Applied after the clear so a same-edge set of the same register wins.
    if (w_issue) pending_d[RdE] = 1'b1;
    pending_d[0] = 1'b0;
    outst_d = outst_q;
    case ({w_issue, w_done})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (DCacheMiss)      state_d = S_DMISS;
        else if (ICacheMiss) state_d = S_IMISS;
      end
      S_DMISS: begin
        if (!DCacheMiss && ICacheMiss)       state_d = S_IMISS;
        else if (!DCacheMiss && !ICacheMiss) state_d = S_IDLE;
      end
      S_IMISS: begin
        if (DCacheMiss)       state_d = S_DMISS;
        else if (!ICacheMiss) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counts entries into a miss state and every D<->I switch.
  assign w_miss_evt = (state_d != state_q) & (state_d != S_IDLE);

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      outst_q     <= '0;
      stall_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      outst_q   <= outst_d;
      if (StallF && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (w_miss_evt && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign MissCnt  = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard_unit
// Purpose  : Self-checking bench for hazard_scoreboard_unit. Combinational
//            cases from a vector table, multicycle corners as hand sequences.
//            Expected controls travel through a queue from drive to sample.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard_unit;

  localparam int REG_AW   = 5;
  localparam int MAX_LONG = 4;
  localparam int CNT_W    = 4;   // narrow so counter saturation is reachable

  // {StallF,StallD,StallE,StallM,StallW, FlushF,FlushD,FlushE,FlushM,FlushW}
  localparam logic [9:0] K_NONE   = 10'b00000_00000;
  localparam logic [9:0] K_RAW    = 10'b11000_00100;
  localparam logic [9:0] K_STRUCT = 10'b11100_00010;
  localparam logic [9:0] K_FREEZE = 10'b11110_00001;
  localparam logic [9:0] K_BR     = 10'b00000_01100;
  localparam logic [9:0] K_JAL    = 10'b00000_01000;
  localparam logic [9:0] K_RST    = 10'b00000_11111;

  typedef struct packed {
    logic       rst, imiss, dmiss, bre, jalre, jald;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rrd, rre;
    logic       rwm, rww, meme, longe, donew;
    logic [4:0] longrd;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic [9:0] c;
    logic [1:0] f1, f2;
  } vec_t;

  typedef struct {
    logic [9:0] c;
    logic [1:0] f1, f2;
    string      tag;
  } exp_t;

  logic CPU_CLK = 1'b0;
  logic CPU_RST, ICacheMiss, DCacheMiss, BranchE, JalrE, JalD;
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, LongRdW;
  logic [1:0] RegReadD, RegReadE;
  logic RegWriteM, RegWriteW, MemToRegE, LongOpE, LongDoneW;
  logic StallF, StallD, StallE, StallM, StallW;
  logic FlushF, FlushD, FlushE, FlushM, FlushW;
  logic [1:0] Forward1E, Forward2E;
  logic [CNT_W-1:0] StallCnt, MissCnt;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] stall_tally = '0;
  exp_t exp_q[$];
  vec_t tv[14];

  always #5 CPU_CLK = ~CPU_CLK;

  hazard_scoreboard_unit #(.REG_AW(REG_AW), .MAX_LONG(MAX_LONG), .CNT_W(CNT_W)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
    .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
    .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegReadD(RegReadD), .RegReadE(RegReadE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .LongOpE(LongOpE),
    .LongDoneW(LongDoneW), .LongRdW(LongRdW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushF(FlushF), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .Forward1E(Forward1E), .Forward2E(Forward2E),
    .StallCnt(StallCnt), .MissCnt(MissCnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input in_t v);
    CPU_RST = v.rst; ICacheMiss = v.imiss; DCacheMiss = v.dmiss;
    BranchE = v.bre; JalrE = v.jalre; JalD = v.jald;
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
    RegReadD = v.rrd; RegReadE = v.rre;
    RegWriteM = v.rwm; RegWriteW = v.rww; MemToRegE = v.meme;
    LongOpE = v.longe; LongDoneW = v.donew; LongRdW = v.longrd;
  endtask

  // One clock cycle: drive after the rising edge, compare at the falling edge.
  task automatic apply(input in_t v, input logic [9:0] c, input logic [1:0] f1,
                       input logic [1:0] f2, input string tag);
    exp_t e;
    #1;
    drive(v);
    e.c = c; e.f1 = f1; e.f2 = f2; e.tag = tag;
    exp_q.push_back(e);
    @(negedge CPU_CLK);
    e = exp_q.pop_front();
    chk({e.tag, ".ctrl"}, {22'd0, StallF, StallD, StallE, StallM, StallW,
                           FlushF, FlushD, FlushE, FlushM, FlushW}, {22'd0, e.c});
    chk({e.tag, ".fwd"}, {28'd0, Forward1E, Forward2E}, {28'd0, e.f1, e.f2});
    if (v.rst) stall_tally = '0;
    else if (e.c[9] && stall_tally != '1) stall_tally = stall_tally + 1'b1;
    @(posedge CPU_CLK);
  endtask

  task automatic chk_cnt(input logic [CNT_W-1:0] miss_req, input string tag);
    #1;
    chk({tag, ".StallCnt"}, {28'd0, StallCnt}, {28'd0, stall_tally});
    chk({tag, ".MissCnt"}, {28'd0, MissCnt}, {28'd0, miss_req});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t v;

    for (int k = 0; k < 14; k++) begin
      tv[k] = '0;
    end
    // 0 idle
    tv[0].c = K_NONE;
    // 1 load x5 in E, D rs1 reads x5
    tv[1].i.meme = 1; tv[1].i.rde = 5; tv[1].i.rs1d = 5; tv[1].i.rrd = 2'b10; tv[1].c = K_RAW;
    // 2 only rs2 used and it is x6: no hazard
    tv[2].i.meme = 1; tv[2].i.rde = 5; tv[2].i.rs1d = 5; tv[2].i.rs2d = 6; tv[2].i.rrd = 2'b01;
    tv[2].c = K_NONE;
    // 3 x0 never hazards
    tv[3].i.meme = 1; tv[3].i.rde = 0; tv[3].i.rrd = 2'b11; tv[3].c = K_NONE;
    // 4 branch in E beats load-use
    tv[4].i = tv[1].i; tv[4].i.bre = 1; tv[4].c = K_BR;
    // 5 jal in D
    tv[5].i.jald = 1; tv[5].c = K_JAL;
    // 6 jal in D beats load-use
    tv[6].i = tv[1].i; tv[6].i.jald = 1; tv[6].c = K_JAL;
    // 7 rs2 forward from M (M beats W)
    tv[7].i.rdm = 7; tv[7].i.rdw = 7; tv[7].i.rwm = 1; tv[7].i.rww = 1;
    tv[7].i.rs2e = 7; tv[7].i.rre = 2'b01; tv[7].c = K_NONE; tv[7].f2 = 2'b10;
    // 8 RdM=0 -> rs2 from W
    tv[8].i = tv[7].i; tv[8].i.rdm = 0; tv[8].c = K_NONE; tv[8].f2 = 2'b01;
    // 9 M not writing -> both sources from W
    tv[9].i.rdm = 7; tv[9].i.rdw = 7; tv[9].i.rww = 1; tv[9].i.rs1e = 7; tv[9].i.rs2e = 7;
    tv[9].i.rre = 2'b11; tv[9].c = K_NONE; tv[9].f1 = 2'b01; tv[9].f2 = 2'b01;
    // 10 sources unused -> no forwarding
    tv[10].i = tv[7].i; tv[10].i.rre = 2'b00; tv[10].c = K_NONE;
    // 11 rs1 from M over W
    tv[11].i.rdm = 3; tv[11].i.rdw = 3; tv[11].i.rwm = 1; tv[11].i.rww = 1; tv[11].i.rs1e = 3;
    tv[11].i.rre = 2'b10; tv[11].c = K_NONE; tv[11].f1 = 2'b10;
    // 12 long op in E, D rs2 reads its Rd -> RAW (flushed, so no issue)
    tv[12].i.longe = 1; tv[12].i.rde = 9; tv[12].i.rs2d = 9; tv[12].i.rrd = 2'b01; tv[12].c = K_RAW;
    // 13 W writing x0 is not forwarded
    tv[13].i.rdw = 0; tv[13].i.rww = 1; tv[13].i.rre = 2'b10; tv[13].c = K_NONE;

    // reset state
    v = '0; v.rst = 1;
    v.rdm = 7; v.rwm = 1; v.rs1e = 7; v.rre = 2'b10;
    apply(v, K_RST, 2'b00, 2'b00, "reset0");
    apply(v, K_RST, 2'b00, 2'b00, "reset1");
    chk_cnt(0, "after_reset");

    for (int k = 0; k < 14; k++) begin
      apply(tv[k].i, tv[k].c, tv[k].f1, tv[k].f2, $sformatf("vec%0d", k));
    end

    // load-use: stall one cycle, then forward from M
    v = '0; v.meme = 1; v.rde = 5; v.rs1d = 5; v.rrd = 2'b10;
    apply(v, K_RAW, 2'b00, 2'b00, "lduse_stall");
    v = '0; v.rdm = 5; v.rwm = 1; v.rs1e = 5; v.rre = 2'b10;
    apply(v, K_NONE, 2'b10, 2'b00, "lduse_fwd");
    chk_cnt(0, "after_lduse");

    // div x9: consumer stalls until LongDoneW, released the following cycle
    v = '0; v.longe = 1; v.rde = 9;
    apply(v, K_NONE, 2'b00, 2'b00, "div_issue");
    v = '0; v.rs1d = 9; v.rrd = 2'b10;
    for (int k = 0; k < 20; k++) apply(v, K_RAW, 2'b00, 2'b00, "div_wait");
    v.donew = 1; v.longrd = 9;
    apply(v, K_RAW, 2'b00, 2'b00, "div_done_cycle");
    v.donew = 0;
    apply(v, K_NONE, 2'b00, 2'b00, "div_released");
    chk_cnt(0, "stallcnt_saturated");

    // fill all long-op slots, 5th op stalls until a completion
    for (int k = 0; k < 4; k++) begin
      v = '0; v.longe = 1; v.rde = 5'(10 + k);
      apply(v, K_NONE, 2'b00, 2'b00, "long_issue");
    end
    v = '0; v.longe = 1; v.rde = 14;
    for (int k = 0; k < 3; k++) apply(v, K_STRUCT, 2'b00, 2'b00, "long_full");
    v.donew = 1; v.longrd = 10;
    apply(v, K_STRUCT, 2'b00, 2'b00, "long_full_done");
    v.donew = 0;
    apply(v, K_NONE, 2'b00, 2'b00, "long_5th_issue");
    v = '0; v.donew = 1; v.longrd = 12;
    apply(v, K_NONE, 2'b00, 2'b00, "done12");
    v = '0; v.longe = 1; v.rde = 13;
    apply(v, K_STRUCT, 2'b00, 2'b00, "waw_x13");
    for (int k = 0; k < 3; k++) begin
      v = '0; v.donew = 1; v.longrd = (k == 0) ? 5'd11 : (k == 1) ? 5'd13 : 5'd14;
      apply(v, K_NONE, 2'b00, 2'b00, "drain");
    end
    // stray completion with nothing outstanding must not underflow
    v = '0; v.donew = 1; v.longrd = 20;
    apply(v, K_NONE, 2'b00, 2'b00, "done_underflow");
    for (int k = 0; k < 4; k++) begin
      v = '0; v.longe = 1; v.rde = 5'(20 + k);
      apply(v, K_NONE, 2'b00, 2'b00, "refill_issue");
    end
    v = '0; v.longe = 1; v.rde = 24;
    apply(v, K_STRUCT, 2'b00, 2'b00, "full_after_underflow");
    for (int k = 0; k < 4; k++) begin
      v = '0; v.donew = 1; v.longrd = 5'(20 + k);
      apply(v, K_NONE, 2'b00, 2'b00, "drain2");
    end

    // D-miss with branch held; I-miss rises mid-miss and takes over afterwards
    for (int k = 0; k < 5; k++) begin
      v = '0; v.dmiss = 1; v.bre = 1; v.imiss = (k >= 3);
      apply(v, K_FREEZE, 2'b00, 2'b00, "dmiss_freeze");
    end
    chk_cnt(1, "after_dmiss");
    v = '0; v.imiss = 1; v.bre = 1;
    apply(v, K_FREEZE, 2'b00, 2'b00, "imiss_freeze");
    apply(v, K_FREEZE, 2'b00, 2'b00, "imiss_freeze");
    chk_cnt(2, "after_imiss");
    v = '0; v.bre = 1;
    apply(v, K_FREEZE, 2'b00, 2'b00, "miss_exit");
    apply(v, K_BR, 2'b00, 2'b00, "branch_after_miss");
    chk_cnt(2, "after_miss_exit");

    // reset during DMISS with x3 pending
    v = '0; v.longe = 1; v.rde = 3;
    apply(v, K_NONE, 2'b00, 2'b00, "issue_x3");
    v = '0; v.dmiss = 1;
    apply(v, K_FREEZE, 2'b00, 2'b00, "dmiss_pre_rst");
    v = '0; v.rst = 1; v.dmiss = 1; v.rdm = 7; v.rwm = 1; v.rs1e = 7; v.rre = 2'b10;
    apply(v, K_RST, 2'b00, 2'b00, "rst_mid_miss");
    chk_cnt(0, "after_mid_rst");
    v = '0; v.rs1d = 3; v.rrd = 2'b10;
    apply(v, K_NONE, 2'b00, 2'b00, "post_rst_x3_free");
    v = '0; v.donew = 1; v.longrd = 3;
    apply(v, K_NONE, 2'b00, 2'b00, "late_done");
    v = '0; v.longe = 1; v.rde = 3;
    apply(v, K_NONE, 2'b00, 2'b00, "reissue_x3");
    v = '0; v.rs1d = 3; v.rrd = 2'b10;
    apply(v, K_RAW, 2'b00, 2'b00, "x3_pending_again");
    chk_cnt(0, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
